seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Runtime-programmable serial pattern detector: matches a 1..MAX_LEN-bit pattern on a
//  qualified serial bit stream, with overlapping or non-overlapping match mode.
//  Flags each match with a one-cycle pulse and keeps a saturating match counter.
//  Next generation of the fixed "11011" detector; reset config reproduces that block.
// PARAMETERS
//  MAX_LEN      8          longest supported pattern, bits (>=2)
//  CNT_W        16         match counter width
//  RST_PATTERN  'b11011    pattern loaded at reset (LSB = last bit received)
//  RST_LEN      5          pattern length loaded at reset
//  RST_OVERLAP  1          overlap mode loaded at reset
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  rst          in   1            asynchronous, active-high reset
//  in_valid     in   1            in_bit qualifier; bit accepted when high
//  in_bit       in   1            serial data bit
//  cfg_we       in   1            load cfg_* into config registers
//  cfg_pattern  in   MAX_LEN      pattern; bit[len-1] = first bit, bit[0] = last bit
//  cfg_len      in   LEN_W        pattern length; LEN_W = $clog2(MAX_LEN+1)
//  cfg_overlap  in   1            1 = overlapping matches, 0 = non-overlapping
//  cnt_clr      in   1            synchronous clear of match_count/count_sat
//  match        out  1            registered one-cycle match pulse
//  match_count  out  CNT_W        saturating count of matches
//  count_sat    out  1            sticky, high once match_count reaches all-ones
// BEHAVIOUR
//  - Reset: hist=0, fill=0, config=RST_*, match=0, match_count=0, count_sat=0.
//  - hist[MAX_LEN-1:0] shift register, newest bit at hist[0]. fill = valid history depth.
//  - Accept (in_valid & ~cfg_we): hist<={hist[MAX_LEN-2:0],in_bit}; fill<=min(fill+1,MAX_LEN).
//  - Hit when the post-shift history satisfies hist[len-1:0]==pattern[len-1:0] and fill>=len.
//  - match is high exactly in the cycle after the accepting edge; a hit needs an accepted bit.
//  - Overlap=1: fill keeps counting after a hit (e.g. 11011011 gives 2 hits).
//  - Overlap=0: a hit forces fill<=0, so the next hit needs len fresh bits.
//  - in_valid low: no shift, no hit; match drops to 0 the next cycle.
//  - cfg_we: loads config; fill<=0, match<=0. A bit offered in the same cycle is dropped.
//    New config takes effect from the next accepted bit. hist is not cleared.
//  - cfg_len==0: detector disabled, no hits. cfg_len>MAX_LEN: clamped to MAX_LEN at load.
//  - Pattern bits above len-1 are ignored.
//  - match_count: +1 per hit, holds at 2^CNT_W-1; count_sat is set on reaching it.
//  - cnt_clr with a simultaneous hit: match_count<=1, count_sat<=0 (clear, then count).
//  - match itself is not affected by cnt_clr.
//  - rst mid-stream: partial sequence discarded, config returns to RST_*.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - seq_det_pkg: LEN_W function, seq_det_cfg_t struct {pattern, len, overlap},
//    and a clamp_len() function.
//  - One sub-module, seq_det_sat_cnt (CNT_W; inc, clr -> count, sat), instanced once.
//  - Rest in seq_det_prog: config regs, hist/fill regs, masked compare, match flop.
// TESTING
//  1 Default config, stream 1,1,0,1,1,0,1,1 (in_valid=1):
//    match pulses after bits 5 and 8; match_count=2.
//  2 cfg_overlap=0, same pattern and stream: one pulse after bit 5; match_count=1.
//  3 cfg_len=1, pattern 1, stream 1,0,1,1: pulses after bits 1, 3, 4.
//    Then cfg_len=0 with the same stream: no pulses.
//  4 Default config, stream 11011 with in_valid low for 3 cycles between bits 2 and 3:
//    exactly one pulse, one cycle after bit 5 is accepted.
//  5 CNT_W=4, 20 overlapping hits: match_count=15, count_sat=1.
//    cnt_clr coincident with a hit: match_count=1, count_sat=0.
//  6 Bits 1,1,0,1 then an rst pulse, then bit 1: no match.
//    cfg_we in the same cycle as a final pattern bit: bit dropped, no match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// The config struct is sized by SEQ_MAX_LEN; instantiate seq_det_prog with MAX_LEN equal to it.
package seq_det_pkg;

  localparam int SEQ_MAX_LEN = 8;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int SEQ_LEN_W = len_w(SEQ_MAX_LEN);

  typedef struct packed {
    logic [SEQ_MAX_LEN-1:0] pattern;
    logic [SEQ_LEN_W-1:0]   len;
    logic                   overlap;
  } seq_det_cfg_t;

  function automatic logic [SEQ_LEN_W-1:0] clamp_len(input logic [SEQ_LEN_W-1:0] len);
    return (len > SEQ_LEN_W'(SEQ_MAX_LEN)) ? SEQ_LEN_W'(SEQ_MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter with sticky saturation flag; one-cycle update latency.
// Clear wins over hold but still counts a coincident increment; never stalls its source.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
      sat   <= 1'b0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
      if (count == CNT_MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector; match is registered one cycle after the accepting edge.
// No backpressure: every valid bit is taken except in a config-write cycle, where it is dropped.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = SEQ_MAX_LEN,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b11011,
  parameter int                 RST_LEN     = 5,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  seq_det_cfg_t       cfg_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_inc;
  logic               accept;
  logic               hit;

  // Compare on the post-shift history so the hit lines up with the accepted bit.
  always_comb begin
    accept   = in_valid & ~cfg_we;
    hist_nxt = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < cfg_q.len);
    end
    hit = accept && (cfg_q.len != '0) && (fill_inc >= cfg_q.len) &&
          (((hist_nxt ^ cfg_q.pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= '{pattern: RST_PATTERN, len: clamp_len(LEN_W'(RST_LEN)), overlap: RST_OVERLAP};
      hist_q <= '0;
      fill_q <= '0;
      match  <= 1'b0;
    end else if (cfg_we) begin
      cfg_q  <= '{pattern: cfg_pattern, len: clamp_len(cfg_len), overlap: cfg_overlap};
      fill_q <= '0;
      match  <= 1'b0;
    end else begin
      match <= hit;
      if (accept) begin
        hist_q <= hist_nxt;
        fill_q <= (hit && !cfg_q.overlap) ? '0 : fill_inc;
      end
    end
  end

  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit),
    .clr  (cnt_clr),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: expected match per driven cycle is queued and checked after the edge.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = len_w(MAX_LEN);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_det_prog #(
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_count(match_count),
    .count_sat  (count_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected match, check it after the edge.
  task automatic cyc(input string tag, input logic v, input logic b, input logic clr,
                     input logic we, input logic exp);
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    cfg_we   = we;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, 32'(match), 32'(exp_q.pop_front()));
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  // First bit of the stream is s[n-1]; e[i] is the match expected after bit s[i].
  task automatic stream(input string tag, input int n, input logic [31:0] s, input logic [31:0] e);
    for (int i = n - 1; i >= 0; i--) cyc(tag, 1'b1, s[i], 1'b0, 1'b0, e[i]);
  endtask

  task automatic cfg(input string tag, input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_cnt();
    cyc("clr_match", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_count", 32'(match_count), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_sat", 32'(count_sat), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    #1;
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_count", 32'(match_count), 32'd0);
    chk("reset_sat", 32'(count_sat), 32'd0);
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Default 11011 overlapping
    stream("t1_ovl", 8, 32'b11011011, 32'b00001001);
    chk("t1_count", 32'(match_count), 32'd2);
    chk("t1_sat", 32'(count_sat), 32'd0);
    clear_cnt();

    // Non-overlapping
    cfg("t2_cfg", 8'b11011, 4'd5, 1'b0);
    stream("t2_novl", 8, 32'b11011011, 32'b00001000);
    chk("t2_count", 32'(match_count), 32'd1);
    clear_cnt();

    // Single-bit pattern, then disabled
    cfg("t3_cfg", 8'b1, 4'd1, 1'b1);
    stream("t3_len1", 4, 32'b1011, 32'b1011);
    chk("t3_count", 32'(match_count), 32'd3);
    cfg("t3_cfg0", 8'b1, 4'd0, 1'b1);
    stream("t3_len0", 4, 32'b1011, 32'b0000);
    chk("t3_count0", 32'(match_count), 32'd3);
    clear_cnt();

    // Oversized length clamps to MAX_LEN
    cfg("clamp_cfg", 8'hFF, 4'd15, 1'b1);
    stream("clamp", 9, 32'h1FF, 32'b000000011);
    chk("clamp_count", 32'(match_count), 32'd2);
    clear_cnt();

    // Pattern bits above len are ignored
    cfg("mask_cfg", 8'b11100101, 4'd3, 1'b1);
    stream("mask", 5, 32'b10101, 32'b00101);
    chk("mask_count", 32'(match_count), 32'd2);
    clear_cnt();

    // Gaps in in_valid
    cfg("t4_cfg", 8'b11011, 4'd5, 1'b1);
    stream("t4_a", 2, 32'b11, 32'b00);
    for (int i = 0; i < 3; i++) cyc("t4_gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stream("t4_b", 3, 32'b011, 32'b001);
    cyc("t4_drop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_count", 32'(match_count), 32'd1);
    clear_cnt();

    // Saturation with 20 overlapping hits, then clear coincident with a hit
    cfg("t5_cfg", 8'b11011, 4'd5, 1'b1);
    for (int k = 1; k <= 62; k++) begin
      cyc("t5_sat", 1'b1, logic'((k - 1) % 3 != 2), 1'b0, 1'b0,
          logic'(k >= 5 && (k - 5) % 3 == 0));
      if (k == 44) begin
        chk("t5_count14", 32'(match_count), 32'd14);
        chk("t5_sat14", 32'(count_sat), 32'd0);
      end
    end
    chk("t5_count", 32'(match_count), 32'd15);
    chk("t5_satf", 32'(count_sat), 32'd1);
    cyc("t5_tail", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t5_tail", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5_clrhit", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_clr_count", 32'(match_count), 32'd1);
    chk("t5_clr_sat", 32'(count_sat), 32'd0);

    // Reset mid-stream discards the partial sequence
    cfg("t6_cfg", 8'b11011, 4'd5, 1'b1);
    stream("t6_pre", 4, 32'b1101, 32'b0000);
    pulse_rst();
    cyc("t6_post", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset restores the default configuration
    cfg("t6_cfg1", 8'b1, 4'd1, 1'b1);
    pulse_rst();
    stream("t6_dflt", 5, 32'b11011, 32'b00001);
    chk("t6_count", 32'(match_count), 32'd1);

    // Config write drops a coincident bit
    cfg("t6_cfg2", 8'b11011, 4'd5, 1'b1);
    stream("t6_we_pre", 4, 32'b1101, 32'b0000);
    cyc("t6_we_bit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("t6_we_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_we_count", 32'(match_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
